// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM states and default datapath width for the
// multi-cycle ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_OR    = 4'd3,
        OP_AND   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_SLT   = 4'd6,
        OP_XOR   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MULLO = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } alu_state_e;

    function automatic logic is_iter_op(input alu_op_e op);
        return (op == OP_MULLO) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One step per enabled edge; the next-step values are exposed so the caller
// can capture the final answer on the same edge as the last step.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;

    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, mcand_q & {WIDTH{lo_q[0]}}};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, mcand_q};
        // A zero divisor always "subtracts": quotient fills with ones and the
        // remainder ends up holding the dividend, with no special-case mux.
        take    = ~diff[WIDTH] | dz_q;
        if (div_q) begin
            hi_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_next = {lo_q[WIDTH-2:0], take};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        dz_d    = dz_q;
        if (load) begin
            hi_d    = '0;
            lo_d    = is_div ? a : b;
            mcand_d = is_div ? b : a;
            cnt_d   = '0;
            div_d   = is_div;
            dz_d    = (b == '0);
        end else if (step) begin
            hi_d  = hi_next;
            lo_d  = lo_next;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle logic/arith/shift ops and WIDTH-cycle iterative
// multiply/divide; done pulses once per completed request.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       ALUopcode,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             sign,
    output logic             zero,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    alu_op_e          op_in;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_err;
    logic             iter_load;
    logic             iter_step;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic             iter_last;

    assign op_in = alu_op_e'(ALUopcode);
    assign shamt = rega[SH_W-1:0];

    always_comb begin
        comb_res = '0;
        comb_err = 1'b0;
        case (op_in)
            OP_ADD:  comb_res = rega + regb;
            OP_SUB:  comb_res = rega - regb;
            OP_SLL:  comb_res = regb << shamt;
            OP_OR:   comb_res = rega | regb;
            OP_AND:  comb_res = rega & regb;
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (rega < regb)};
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
            OP_XOR:  comb_res = rega ^ regb;
            OP_SRL:  comb_res = regb >> shamt;
            OP_SRA:  comb_res = $unsigned($signed(regb) >>> shamt);
            OP_MULLO, OP_MULHU, OP_DIVU, OP_REMU: comb_res = '0;
            default: comb_err = 1'b1;
        endcase
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (CLK),
        .rst     (Reset),
        .load    (iter_load),
        .step    (iter_step),
        .is_div  ((op_in == OP_DIVU) || (op_in == OP_REMU)),
        .a       (rega),
        .b       (regb),
        .hi_next (iter_hi),
        .lo_next (iter_lo),
        .last    (iter_last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        done_d    = 1'b0;
        err_d     = err_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_iter_op(op_in)) begin
                        state_d   = S_RUN;
                        op_d      = op_in;
                        iter_load = 1'b1;
                    end else begin
                        result_d = comb_res;
                        err_d    = comb_err;
                        done_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: requests while busy are dropped
                iter_step = 1'b1;
                if (iter_last) begin
                    result_d = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? iter_hi : iter_lo;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;
    assign sign   = result_q[WIDTH-1];
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations queued at issue time,
// popped and compared when done pulses.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ALUopcode = 4'd0;
    logic [W-1:0] rega = '0;
    logic [W-1:0] regb = '0;
    logic         busy, done, sign, zero, err;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        logic [3:0]   op;
    } exp_t;

    exp_t sb[$];

    alu_multicycle #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .ALUopcode (ALUopcode),
        .rega      (rega),
        .regb      (regb),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sign      (sign),
        .zero      (zero),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        logic [4:0] sh;
        e.res = '0;
        e.err = 1'b0;
        e.op  = op;
        sh    = a[4:0];
        p     = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = b << sh;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a & b;
            4'd5:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd6:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = b >> sh;
            4'd9:  e.res = $unsigned($signed(b) >>> sh);
            4'd10: e.res = p[W-1:0];
            4'd11: e.res = p[2*W-1:W];
            4'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: e.res = (b == 0) ? a : a % b;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        ALUopcode = op;
        rega      = a;
        regb      = b;
        start     = 1'b1;
        sb.push_back(model(op, a, b));
        @(negedge CLK);
        start = 1'b0;
    endtask

    // cyc: edges after the sampling edge until done is seen; bc: busy samples
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!done && cyc < 200) begin
            if (busy) bc++;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl busy/done/err got %b want 000", {busy, done, err});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got %h want 00000000", result);
        end
        checks++;
        if ({zero, sign} !== 2'b10) begin
            errors++;
            $display("FAIL reset_flags zero/sign got %b want 10", {zero, sign});
        end
        Reset = 1'b0;
    endtask

    task automatic test_single_cycle;
        logic [3:0]   ops [0:10] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        logic [W-1:0] as  [0:10] = '{32'h7FFF_FFFF, 32'h0, 32'd4, 32'h24, 32'hF0F0_0000, 32'hFF00_FF00,
                                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'd4, 32'd4};
        logic [W-1:0] bs  [0:10] = '{32'h1, 32'h1, 32'h1, 32'hF, 32'h0000_0F0F, 32'h0F0F_0F0F,
                                     32'h1, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        int cyc, bc;
        exp_t e;
        for (int i = 0; i < 19; i++) begin
            if (i < 11) send(ops[i], as[i], bs[i]);
            else if (i == 11) send(4'd0, 32'hFFFF_FFFF, 32'h1);
            else send(4'($urandom_range(0, 9)), $urandom, $urandom);
            wait_done(cyc, bc);
            e = sb.pop_front();
            checks++;
            if (!done || cyc != 0 || bc != 0) begin
                errors++;
                $display("FAIL single_latency op %0d got cyc=%0d busy=%0d want cyc=0 busy=0", e.op, cyc, bc);
            end
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL single_result op %0d got %h want %h", e.op, result, e.res);
            end
            checks++;
            if ({sign, zero, err} !== {e.res[W-1], e.res == 0, 1'b0}) begin
                errors++;
                $display("FAIL single_flags op %0d sign/zero/err got %b want %b", e.op,
                         {sign, zero, err}, {e.res[W-1], e.res == 0, 1'b0});
            end
        end
    endtask

    task automatic test_iterative;
        logic [3:0]   ops [0:7] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13, 4'd12, 4'd11};
        logic [W-1:0] as  [0:7] = '{32'h0001_0000, 32'h0001_0000, 32'd100, 32'd100, 32'd5, 32'd5,
                                    32'd7, 32'hFFFF_FFFF};
        logic [W-1:0] bs  [0:7] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0,
                                    32'd100, 32'hFFFF_FFFF};
        int cyc, bc;
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) send(ops[i], as[i], bs[i]);
            else send(4'($urandom_range(10, 13)), $urandom, (i == 13) ? 32'd3 : $urandom);
            wait_done(cyc, bc);
            e = sb.pop_front();
            checks++;
            if (!done || cyc != 32 || bc != 32) begin
                errors++;
                $display("FAIL iter_latency op %0d got cyc=%0d busy=%0d want cyc=32 busy=32", e.op, cyc, bc);
            end
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL iter_result op %0d got %h want %h", e.op, result, e.res);
            end
            checks++;
            if ({sign, zero, err} !== {e.res[W-1], e.res == 0, 1'b0}) begin
                errors++;
                $display("FAIL iter_flags op %0d sign/zero/err got %b want %b", e.op,
                         {sign, zero, err}, {e.res[W-1], e.res == 0, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        exp_t e;
        send(4'd10, 32'h0001_2345, 32'h0006_789A);
        repeat (5) @(negedge CLK);
        // request while busy: must be dropped, so nothing is queued for it
        ALUopcode = 4'd0;
        rega      = 32'd1;
        regb      = 32'd2;
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done(cyc, bc);
        e = sb.pop_front();
        checks++;
        if (!done || result !== e.res) begin
            errors++;
            $display("FAIL ignore_busy done=%b got %h want %h", done, result, e.res);
        end
        // accept a new request in the done cycle
        ALUopcode = 4'd1;
        rega      = 32'd10;
        regb      = 32'd3;
        start     = 1'b1;
        sb.push_back(model(4'd1, 32'd10, 32'd3));
        @(negedge CLK);
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || result !== e.res) begin
            errors++;
            $display("FAIL back_to_back done=%b got %h want %h", done, result, e.res);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== e.res) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b result=%h want 0 0 %h", done, busy, result, e.res);
        end
    endtask

    task automatic test_reset_abort;
        int cyc, bc;
        bit seen;
        exp_t e;
        send(4'd12, 32'd100, 32'd7);
        repeat (9) @(negedge CLK);
        Reset = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if ({busy, done} !== 2'b00 || result !== '0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b result=%h zero=%b want 0 0 00000000 1",
                     busy, done, result, zero);
        end
        @(negedge CLK);
        Reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_done got done pulse want none");
        end
        send(4'd12, 32'd100, 32'd7);
        wait_done(cyc, bc);
        e = sb.pop_front();
        checks++;
        if (!done || cyc != 32 || result !== e.res) begin
            errors++;
            $display("FAIL after_abort cyc=%0d got %h want cyc=32 %h", cyc, result, e.res);
        end
    endtask

    task automatic test_illegal;
        int cyc, bc;
        exp_t e;
        for (int i = 14; i < 16; i++) begin
            send(4'(i), 32'h1234_5678, 32'h9ABC_DEF0);
            wait_done(cyc, bc);
            e = sb.pop_front();
            checks++;
            if (!done || cyc != 0 || result !== e.res || err !== e.err || zero !== 1'b1) begin
                errors++;
                $display("FAIL illegal op %0d done=%b result=%h err=%b want 1 %h %b",
                         i, done, result, err, e.res, e.err);
            end
        end
        send(4'd0, 32'd3, 32'd4);
        wait_done(cyc, bc);
        e = sb.pop_front();
        checks++;
        if (!done || result !== e.res || err !== e.err) begin
            errors++;
            $display("FAIL err_clear result=%h err=%b want %h %b", result, err, e.res, e.err);
        end
    endtask

    initial begin
        test_reset;
        test_single_cycle;
        test_iterative;
        test_back_to_back;
        test_reset_abort;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
